// File: rtl/mult3_serial_sched.sv
// mult3_serial_sched
// Round-robin scheduler sharing one serial multiple-of-3 detector among
// NREQ requesters. A granted word is latched, the detector is cleared for
// one cycle, the word is shifted in MSB-first (one bit per clock), and the
// detector verdict is returned with the requester ID on a valid/ready
// response channel.
//
// Optional build macro: MULT3_SELF_CHECK_EN
//   Defined   - a reference residue (word mod 3) is tracked alongside the
//               shifted bits and compared with det_out in CAPTURE; any
//               disagreement sets the sticky err output until reset.
//   Undefined - no residue logic is built and err is tied low.

module mult3_serial_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  det_clr,
    output logic                  det_bit,
    input  logic                  det_out,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic                  resp_mult3,
    output logic [WIDTH-1:0]      resp_word,
    output logic                  busy,
    output logic                  err
);

    // Bit counter wide enough to index WIDTH shift cycles (at least 1 bit).
    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_id;
    logic [WIDTH-1:0]    r_word;
    logic [WIDTH-1:0]    r_shift;
    logic [CNTW-1:0]     r_cnt;
    logic                r_det_clr;
    logic                r_det_bit;
    logic                r_resp_valid;
    logic [IDW-1:0]      r_resp_id;
    logic                r_resp_mult3;
    logic [WIDTH-1:0]    r_resp_word;

    logic                w_found;
    logic [IDW-1:0]      w_grant_id;
    logic [NREQ-1:0]     w_grant;
    logic                w_accept;
    logic [WIDTH-1:0]    w_sel_word;
    logic [IDW-1:0]      w_ptr_nxt;
    logic                w_last_bit;

    // ------------------------------------------------------------------
    // Round-robin search: first valid requester at or above the pointer,
    // wrapping modulo NREQ.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        w_found    = 1'b0;
        w_grant_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(r_ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_found && req_valid[IDW'(idx)]) begin
                w_found    = 1'b1;
                w_grant_id = IDW'(idx);
            end
        end
    end

    // Grant is only offered while idle; otherwise requests are ignored.
    assign w_grant    = (r_state == S_IDLE && w_found) ? (NREQ'(1) << w_grant_id) : '0;
    assign req_ready  = w_grant;
    assign w_accept   = |(req_valid & w_grant);
    assign w_sel_word = req_data[w_grant_id*WIDTH +: WIDTH];
    assign w_ptr_nxt  = (w_grant_id == IDW'(NREQ-1)) ? '0 : w_grant_id + IDW'(1);
    assign w_last_bit = (r_cnt == CNTW'(WIDTH-1));

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode for the accept / clear / shift / capture / respond flow.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept)   w_state_nxt = S_CLEAR;
            S_CLEAR:                   w_state_nxt = S_SHIFT;
            S_SHIFT:   if (w_last_bit) w_state_nxt = S_CAPTURE;
            S_CAPTURE:                 w_state_nxt = S_RESP;
            S_RESP:    if (resp_ready) w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: word latch, pointer, serial shift, detector drive and
    // response registers. All registers are reset so an aborted word
    // leaves nothing behind.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_word       <= '0;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_det_clr    <= 1'b1;
            r_det_bit    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_mult3 <= 1'b0;
            r_resp_word  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // det_clr is raised only for the cycle spent in CLEAR.
                    r_det_clr <= w_accept;
                    r_det_bit <= 1'b0;
                    if (w_accept) begin
                        r_word  <= w_sel_word;
                        r_shift <= w_sel_word;
                        r_id    <= w_grant_id;
                        r_ptr   <= w_ptr_nxt;
                        r_cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    // Present the MSB for the first SHIFT cycle.
                    r_det_clr <= 1'b0;
                    r_det_bit <= r_shift[WIDTH-1];
                    r_shift   <= r_shift << 1;
                    r_cnt     <= '0;
                end
                S_SHIFT: begin
                    if (w_last_bit) begin
                        r_det_bit <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_det_bit <= r_shift[WIDTH-1];
                        r_shift   <= r_shift << 1;
                        r_cnt     <= r_cnt + CNTW'(1);
                    end
                end
                S_CAPTURE: begin
                    // Detector has now absorbed all WIDTH bits.
                    r_resp_valid <= 1'b1;
                    r_resp_mult3 <= det_out;
                    r_resp_id    <= r_id;
                    r_resp_word  <= r_word;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_det_clr <= 1'b1;
                end
            endcase
        end
    end

`ifdef MULT3_SELF_CHECK_EN
    logic [1:0] r_res;
    logic       r_err;

    // Residue of (2*r + b) mod 3 for one more MSB-first bit.
    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        logic [1:0] n;
        case ({r, b})
            3'b000:  n = 2'd0;
            3'b001:  n = 2'd1;
            3'b010:  n = 2'd2;
            3'b011:  n = 2'd0;
            3'b100:  n = 2'd1;
            3'b101:  n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Track the reference residue of the bits being shifted and flag a
    // detector verdict that disagrees with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res <= 2'd0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR:   r_res <= 2'd0;
                S_SHIFT:   r_res <= mod3_step(r_res, r_det_bit);
                S_CAPTURE: if ((r_res == 2'd0) != det_out) r_err <= 1'b1;
                default:   r_res <= r_res;
            endcase
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign det_clr    = r_det_clr;
    assign det_bit    = r_det_bit;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_mult3 = r_resp_mult3;
    assign resp_word  = r_resp_word;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult3_serial_sched.sv
// Testbench for mult3_serial_sched: directed vectors, expected responses
// queued at issue time and compared by an independent response monitor.
module tb_mult3_serial_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;
    localparam int LAT   = WIDTH + 3;
    localparam int PERIOD_CYC = WIDTH + 4;
`ifdef MULT3_SELF_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  det_clr;
    logic                  det_bit;
    logic                  det_out;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic                  resp_mult3;
    logic [WIDTH-1:0]      resp_word;
    logic                  busy;
    logic                  err;

    typedef struct {
        logic [IDW-1:0]   id;
        logic             mult3;
        logic [WIDTH-1:0] word;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   acc_hist[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   m_res   = 0;
    logic tb_inv  = 1'b0;
    logic prev_valid = 1'b0;

    mult3_serial_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .det_clr    (det_clr),
        .det_bit    (det_bit),
        .det_out    (det_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_mult3 (resp_mult3),
        .resp_word  (resp_word),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural serial detector: synchronous clear, residue of prefix.
    always @(posedge clk) begin
        if (det_clr) m_res <= 0;
        else         m_res <= (2 * m_res + int'(det_bit)) % 3;
    end
    assign det_out = (m_res == 0) ^ tb_inv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record accept cycles as observed on the request handshake.
    always @(negedge clk) begin
        if (!reset && |(req_valid & req_ready)) begin
            acc_q.push_back(cyc);
            acc_hist.push_back(cyc);
        end
    end

    // Response monitor: latency on rising valid, field check every valid
    // cycle (covers hold stability), pop on handshake.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (resp_valid && !prev_valid) begin
                if (acc_q.size() > 0) check("resp_latency", cyc, acc_q[0] + LAT);
                else                  check("resp_without_accept", 1, 0);
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    check("resp_id",    resp_id,    sb[0].id);
                    check("resp_mult3", resp_mult3, sb[0].mult3);
                    check("resp_word",  resp_word,  sb[0].word);
                    if (resp_ready) begin
                        sb.pop_front();
                        if (acc_q.size() > 0) acc_q.pop_front();
                    end
                end
            end
            prev_valid <= resp_valid;
        end
    end

    task automatic expect_resp(input int id, input logic [WIDTH-1:0] w, input logic m3);
        exp_t e;
        e.id    = IDW'(id);
        e.mult3 = m3;
        e.word  = w;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy || resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 200), 1);
    endtask

    task automatic send(input int id, input logic [WIDTH-1:0] w, input logic m3);
        int n = 0;
        @(posedge clk); #1;
        req_data[id*WIDTH +: WIDTH] = w;
        req_valid[id] = 1'b1;
        expect_resp(id, w, m3);
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 100);
        check("grant_seen", req_ready[id], 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] bits;
        int base;
        int n;

        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b1;

        // Reset state
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id",    resp_id,    0);
        check("rst_resp_mult3", resp_mult3, 0);
        check("rst_resp_word",  resp_word,  0);
        check("rst_busy",       busy,       0);
        check("rst_err",        err,        0);
        check("rst_det_clr",    det_clr,    1);
        check("rst_det_bit",    det_bit,    0);
        check("rst_req_ready",  req_ready,  0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("det_clr_before_edge", det_clr, 1);
        @(posedge clk); #1;
        check("det_clr_after_edge", det_clr, 0);

        // Single request: requester 2, word 9
        @(posedge clk); #1;
        req_data[2*WIDTH +: WIDTH] = 8'd9;
        req_valid = 4'b0100;
        expect_resp(2, 8'd9, 1'b1);
        @(negedge clk);
        check("t1_req_ready", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("t1_clear_det_clr", det_clr, 1);
        check("t1_clear_det_bit", det_bit, 0);
        check("t1_clear_busy",    busy,    1);
        check("t1_clear_ready",   req_ready, 0);
        bits = 8'd9;
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            check("t1_det_bit", det_bit, bits[WIDTH-1-k]);
            check("t1_shift_det_clr", det_clr, 0);
        end
        wait_idle("t1_drain");

        // Back-pressure: requester 0, word 10, resp_ready low 5 cycles
        @(posedge clk); #1;
        resp_ready = 1'b0;
        send(0, 8'd10, 1'b0);
        @(posedge clk); #1;
        req_valid = 4'b1110;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            check("t2_no_grant_busy", req_ready, 0);
            n++;
        end
        check("t2_resp_seen", resp_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("t2_hold_valid", resp_valid, 1);
            check("t2_hold_busy",  busy,       1);
            check("t2_hold_ready", req_ready,  0);
        end
        @(posedge clk); #1;
        req_valid  = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_idle_busy",  busy,       0);
        check("t2_idle_valid", resp_valid, 0);

        // Boundary words
        send(0, 8'd0,   1'b1);
        send(1, 8'd255, 1'b1);
        send(3, 8'd254, 1'b0);
        wait_idle("t3_drain");

        // Round robin with all requesters continuously valid
        do_reset();
        base = acc_hist.size();
        @(posedge clk); #1;
        req_data = {8'd24, 8'd23, 8'd22, 8'd21};
        expect_resp(0, 8'd21, 1'b1);
        expect_resp(1, 8'd22, 1'b0);
        expect_resp(2, 8'd23, 1'b0);
        expect_resp(3, 8'd24, 1'b1);
        expect_resp(0, 8'd21, 1'b1);
        req_valid = 4'b1111;
        n = 0;
        while (acc_hist.size() < base + 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_five_grants", (acc_hist.size() >= base + 5), 1);
        @(posedge clk); #1;
        req_valid = '0;
        if (acc_hist.size() >= base + 5) begin
            for (int i = 1; i < 5; i++) begin
                check("t4_spacing", acc_hist[base+i] - acc_hist[base+i-1], PERIOD_CYC);
            end
        end
        wait_idle("t4_drain");

        // Reset in the 3rd SHIFT cycle
        @(posedge clk); #1;
        req_data[1*WIDTH +: WIDTH] = 8'd33;
        req_valid = 4'b0010;
        expect_resp(1, 8'd33, 1'b1);
        @(negedge clk);
        check("t5_req_ready", req_ready, 4'b0010);
        @(posedge clk); #1;                // CLEAR
        req_valid = '0;
        @(posedge clk);                    // SHIFT 1
        @(posedge clk);                    // SHIFT 2
        @(posedge clk); #1;                // SHIFT 3
        reset = 1'b1;
        void'(sb.pop_back());
        acc_q.delete();
        #1;
        check("t5_rst_resp_valid", resp_valid, 0);
        check("t5_rst_busy",       busy,       0);
        check("t5_rst_det_clr",    det_clr,    1);
        check("t5_rst_det_bit",    det_bit,    0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        req_data[1*WIDTH +: WIDTH] = 8'd6;
        req_data[3*WIDTH +: WIDTH] = 8'd50;
        req_valid = 4'b1010;
        expect_resp(1, 8'd6,  1'b1);
        expect_resp(3, 8'd50, 1'b0);
        @(negedge clk);
        check("t5_first_grant", req_ready, 4'b0010);
        n = 0;
        while (!req_ready[3] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_second_grant", req_ready, 4'b1000);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle("t5_drain");

        // Detector fault: inverted det_out for one word, then a correct word
        @(posedge clk); #1;
        tb_inv = 1'b1;
        send(2, 8'd9, 1'b0);
        wait_idle("t6_bad_drain");
        tb_inv = 1'b0;
        check("t6_err_after_bad", err, EXP_ERR);
        send(2, 8'd12, 1'b1);
        wait_idle("t6_good_drain");
        check("t6_err_sticky", err, EXP_ERR);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
